// File: rtl/ternary_serial_subtractor_pkg.sv
// Shared ternary digit encoding and FSM state type for the ternary adder/subtractor family.
// Digits are {d1,d0} = 0,1,2; 2'b11 is the illegal code.
package tern_pkg;

  typedef logic [1:0] digit_t;

  localparam digit_t TD0    = 2'b00;
  localparam digit_t TD1    = 2'b01;
  localparam digit_t TD2    = 2'b10;
  localparam digit_t TD_BAD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The illegal code reads as digit 0 wherever no explicit check is made.
  function automatic digit_t digit_val(input digit_t x);
    return (x == TD_BAD) ? TD0 : x;
  endfunction

endpackage

// File: rtl/ternary_serial_subtractor_if.sv
// Stream bundle for the digit-serial ternary subtractor: input digit pairs, result digits,
// the sticky error flag and the FSM state for observation.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both high; while
// valid is high and ready is low the sender holds valid and its data stable.
interface ternary_serial_subtractor_if;
  import tern_pkg::*;

  logic         in_valid;
  logic         in_ready;
  digit_t       in_a;
  digit_t       in_b;
  logic         in_last;

  logic         out_valid;
  logic         out_ready;
  digit_t       out_d;
  logic         out_last;
  logic         out_borrow;

  logic         err;
  state_t       dbg_state;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_d, out_last, out_borrow, err, dbg_state
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_d, out_last, out_borrow, err, dbg_state
  );

endinterface

// File: rtl/ternary_serial_subtractor_fs.sv
// Combinational ternary full subtractor: d = a - b - bin modulo 3, bout set when the raw
// difference goes negative. The illegal code 2'b11 is treated as digit 0.
module ternary_full_subtractor
  import tern_pkg::*;
(
  input  digit_t a,
  input  digit_t b,
  input  logic   bin,
  output digit_t d,
  output logic   bout
);

  logic [2:0] av;
  logic [2:0] bv;
  logic [2:0] s;

  // Offset by 3 so the difference stays non-negative: s in 0..5, s<3 means a borrow.
  always_comb begin
    av   = {1'b0, digit_val(a)};
    bv   = {1'b0, digit_val(b)};
    s    = av + 3'd3 - bv - {2'b00, bin};
    d    = TD0;
    bout = 1'b0;
    if (s < 3'd3) begin
      d    = s[1:0];
      bout = 1'b1;
    end else begin
      d    = 2'(s - 3'd3);
      bout = 1'b0;
    end
  end

endmodule

// File: rtl/ternary_serial_subtractor.sv
// Digit-serial ternary subtractor A - B, LSD first, one digit pair per beat, 1-clk latency.
// Define TERN_ERR_CHK_EN to flag illegal digits (sticky per frame) and force their result to 0.
module ternary_serial_subtractor
  import tern_pkg::*;
#(
  parameter int MAX_DIGITS = 8,
  parameter int CNT_W      = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  ternary_serial_subtractor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DIGITS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic              out_valid_q, out_valid_d;
  digit_t            out_d_q, out_d_d;
  logic              out_last_q, out_last_d;
  logic              out_borrow_q, out_borrow_d;

  logic              in_ready;
  logic              accept;
  logic              first_beat;
  logic              frame_end;
  logic              borrow_in;
  digit_t            cell_d;
  logic              cell_bout;
  digit_t            dig;
  logic              bnext;

  assign in_ready   = !out_valid_q || bus.out_ready;
  assign accept     = bus.in_valid && in_ready;
  assign first_beat = (state_q == IDLE);
  assign frame_end  = bus.in_last || (cnt_q == CNT_LAST);
  // A new frame never inherits the borrow of the previous one.
  assign borrow_in  = first_beat ? 1'b0 : borrow_q;

  ternary_full_subtractor u_cell (
    .a    (bus.in_a),
    .b    (bus.in_b),
    .bin  (borrow_in),
    .d    (cell_d),
    .bout (cell_bout)
  );

`ifdef TERN_ERR_CHK_EN
  logic illegal;
  logic err_q, err_d;

  assign illegal = (bus.in_a == TD_BAD) || (bus.in_b == TD_BAD);
  assign dig     = illegal ? TD0 : cell_d;
  assign bnext   = illegal ? 1'b0 : cell_bout;

  // Sticky within a frame; re-evaluated from scratch on the first beat of the next frame.
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = first_beat ? illegal : (err_q || illegal);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign dig     = cell_d;
  assign bnext   = cell_bout;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    out_valid_d  = out_valid_q;
    out_d_d      = out_d_q;
    out_last_d   = out_last_q;
    out_borrow_d = out_borrow_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_d_d      = dig;
      out_last_d   = frame_end;
      out_borrow_d = frame_end && bnext;
      if (frame_end) begin
        state_d  = IDLE;
        cnt_d    = '0;
        borrow_d = 1'b0;
      end else begin
        state_d  = BUSY;
        cnt_d    = cnt_q + CNT_W'(1);
        borrow_d = bnext;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_d_q      <= TD0;
      out_last_q   <= 1'b0;
      out_borrow_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      out_valid_q  <= out_valid_d;
      out_d_q      <= out_d_d;
      out_last_q   <= out_last_d;
      out_borrow_q <= out_borrow_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_d      = out_d_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_borrow = out_borrow_q;
  assign bus.dbg_state  = state_q;

endmodule
